// File: rtl/ex_pkg.sv
// Shared EX-stage constants for the RV32M multiply/divide sequencer:
// M-op funct3 codes, sequencer state encoding and special-case results.
package ex_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_CNT_W = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [31:0] DIV_OVF_Q     = 32'h80000000;

endpackage

// File: rtl/muldiv_iter_core.sv
// Per-cycle datapath: 64-bit accumulator stepping either an unsigned
// shift-add multiply or a restoring shift-subtract divide on magnitudes.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc
);

  logic [XLEN:0]     sum;
  logic [XLEN:0]     rsh;
  logic              ge;
  logic [XLEN-1:0]   dif;
  logic [2*XLEN-1:0] acc_mul;
  logic [2*XLEN-1:0] acc_div;
  logic [2*XLEN-1:0] acc_nxt;

  // One multiply or divide iteration on the current accumulator
  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]}
            + (acc[0] ? {1'b0, b} : '0);
    acc_mul = {sum, acc[XLEN-1:1]};
    rsh     = acc[2*XLEN-1:XLEN-1];
    ge      = rsh >= {1'b0, b};
    dif     = rsh[XLEN-1:0] - b;
    if (ge)
      acc_div = {dif, acc[XLEN-2:0], 1'b1};
    else
      acc_div = {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    acc_nxt = is_div ? acc_div : acc_mul;
  end

  // Accumulator: {0, a} on load (multiplier/dividend in low half)
  always_ff @(posedge clk) begin
    if (!rst_n)
      acc <= '0;
    else if (load)
      acc <= {{XLEN{1'b0}}, a};
    else if (step)
      acc <= acc_nxt;
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M MUL/DIV/REM sequencer beside the EX ALU; stalls EX while iterating.
// Optional FAST_MUL_EN: MUL* ops use a single-cycle hard multiplier.
module ex_muldiv_seq #(
  parameter int XLEN       = ex_pkg::XLEN,
  parameter int ITER_CNT_W = ex_pkg::ITER_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] op_a_in,
  input  logic [XLEN-1:0] op_b_in,
  input  logic            flush_in,
  output logic            stall_out,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out
);

  import ex_pkg::*;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [ITER_CNT_W-1:0] cnt;
  logic [2:0]            f3;
  logic [XLEN-1:0]       b_abs;
  logic                  res_neg;
  logic [2*XLEN-1:0]     acc;

  logic            is_div_in;
  logic            is_rem_in;
  logic            a_sgn;
  logic            b_sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs_in;
  logic [XLEN-1:0] b_abs_in;
  logic            res_neg_in;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            go_done;
  logic            accept;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_val;
  logic [XLEN-1:0]   div_fix;
  logic [XLEN-1:0]   fix_res;

`ifdef FAST_MUL_EN
  logic signed [2*XLEN-1:0] fa;
  logic signed [2*XLEN-1:0] fb;
  logic signed [2*XLEN-1:0] fm;
  logic [XLEN-1:0]          fast_res;
`endif

  // Operand decode at issue: signedness, magnitudes, special cases
  always_comb begin
    is_div_in = funct3_in[2];
    is_rem_in = funct3_in[2] & funct3_in[1];
    a_sgn     = is_div_in ? ~funct3_in[0]
                          : (funct3_in != F3_MULHU);
    b_sgn     = is_div_in ? ~funct3_in[0]
                          : (funct3_in == F3_MUL ||
                             funct3_in == F3_MULH);
    a_neg     = a_sgn & op_a_in[XLEN-1];
    b_neg     = b_sgn & op_b_in[XLEN-1];
    a_abs_in  = a_neg ? -op_a_in : op_a_in;
    b_abs_in  = b_neg ? -op_b_in : op_b_in;
    res_neg_in = is_rem_in ? a_neg : (a_neg ^ b_neg);
    div_zero  = is_div_in && (op_b_in == '0);
    div_ovf   = is_div_in && !funct3_in[0] &&
                (op_a_in == DIV_OVF_Q) && (op_b_in == '1);
    special   = div_zero | div_ovf;
    if (div_zero)
      special_res = is_rem_in ? op_a_in : DIV_BY_ZERO_Q;
    else
      special_res = is_rem_in ? '0 : DIV_OVF_Q;
`ifdef FAST_MUL_EN
    go_done = special | ~is_div_in;
`else
    go_done = special;
`endif
    accept = (state == ST_IDLE) && start_in && !flush_in;
  end

`ifdef FAST_MUL_EN
  // Single-cycle 33x33 signed product for MUL* ops
  always_comb begin
    fa = {{XLEN{a_neg}}, op_a_in};
    fb = {{XLEN{b_neg}}, op_b_in};
    fm = fa * fb;
    fast_res = (funct3_in == F3_MUL) ? fm[XLEN-1:0]
                                     : fm[2*XLEN-1:XLEN];
  end
`endif

  // Sign fixup of the unsigned iteration result
  always_comb begin
    prod_fix = res_neg ? -acc : acc;
    div_val  = f3[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    div_fix  = res_neg ? -div_val : div_val;
    if (f3[2])
      fix_res = div_fix;
    else if (f3 == F3_MUL)
      fix_res = prod_fix[XLEN-1:0];
    else
      fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  // Next-state: flush always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_in)
                 state_nxt = go_done ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == ITER_CNT_W'(XLEN-1))
                 state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush_in)
      state_nxt = ST_IDLE;
  end

  // State, op capture, iteration counter and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      f3         <= '0;
      b_abs      <= '0;
      res_neg    <= 1'b0;
      result_out <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        f3      <= funct3_in;
        b_abs   <= b_abs_in;
        res_neg <= res_neg_in;
        cnt     <= '0;
      end else if (state == ST_CALC) begin
        cnt <= cnt + 1'b1;
      end
      if (accept && special)
        result_out <= special_res;
`ifdef FAST_MUL_EN
      else if (accept && !is_div_in)
        result_out <= fast_res;
`endif
      else if (state == ST_FIX && !flush_in)
        result_out <= fix_res;
    end
  end

  muldiv_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (state == ST_CALC),
    .is_div (f3[2]),
    .a      (a_abs_in),
    .b      (b_abs),
    .acc    (acc)
  );

  // EX is held from issue until the result is ready
  always_comb begin
    stall_out = ((state == ST_IDLE) && start_in) ||
                (state == ST_CALC) || (state == ST_FIX);
    busy_out  = (state != ST_IDLE);
    done_out  = (state == ST_DONE) && !flush_in;
  end

  a_no_start_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(start_in && (state == ST_CALC || state == ST_FIX)));

endmodule
